// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake game sequencer.
// Purely combinational definitions: no latency, no flow control.
package snake_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_STEP  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  // Opposite directions differ only in the MSB of the encoding.
  function automatic logic is_reversal(input logic [1:0] cur, input logic [1:0] cmd);
    return cmd == (cur ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_tick_div.sv
// Move-tick divider: counts cycles while running, fires tick combinationally at period-1.
// Latency 0 from count to tick; freezes when neither run nor clear, holds 0 on clear.
module snake_tick_div #(
  parameter int P0 = 12500000,
  parameter int P1 = 6250000,
  parameter int P2 = 3125000,
  parameter int P3 = 1562500,
  parameter int CW = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed_mode,
  input  logic       run,
  input  logic       clear,
  output logic       tick
);

  logic [CW-1:0] tick_cnt;
  logic [CW-1:0] period_m1;

  always_comb begin
    case (speed_mode)
      2'd0:    period_m1 = CW'(P0 - 1);
      2'd1:    period_m1 = CW'(P1 - 1);
      2'd2:    period_m1 = CW'(P2 - 1);
      default: period_m1 = CW'(P3 - 1);
    endcase
  end

  // >= rather than == so a switch to a shorter period fires at once.
  assign tick = run && (tick_cnt >= period_m1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else if (run) begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/snake_step_scheduler.sv
// Snake game sequencer: tick-paced step handshake, direction buffer, pause/restart, beeper.
// step_req rises the cycle after a tick and holds until step_ack; no new tick while waiting.
module snake_step_scheduler
  import snake_pkg::*;
#(
  parameter int P0        = 12500000,
  parameter int P1        = 6250000,
  parameter int P2        = 3125000,
  parameter int P3        = 1562500,
  parameter int BEEP_EAT  = 2500000,
  parameter int BEEP_OVER = 12500000,
  parameter int CW        = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed_mode,
  input  logic       key,
  input  logic       dir_valid,
  input  logic [1:0] dir_code,
  input  logic       step_ack,
  input  logic       collision,
  input  logic       eat,
  output logic       init_req,
  output logic       step_req,
  output logic [1:0] step_dir,
  output logic [2:0] game_state,
  output logic       beep_en
);

  localparam logic [CW-1:0] BEEP_EAT_C  = CW'(BEEP_EAT);
  localparam logic [CW-1:0] BEEP_OVER_C = CW'(BEEP_OVER);

  logic [2:0]    state;
  logic [1:0]    cur_dir;
  logic [1:0]    pend_dir;
  logic          pend_valid;
  logic          pause_pend;
  logic          key_q;
  logic [CW-1:0] beep_cnt;
  logic          key_rise;
  logic          tick;
  logic          dir_accept;
  logic [1:0]    next_dir;

  assign key_rise   = key & ~key_q;
  assign next_dir   = pend_valid ? pend_dir : cur_dir;
  assign game_state = state;
  assign beep_en    = (beep_cnt != '0);

  // Commands are judged against the committed heading, never the buffered one.
  assign dir_accept = dir_valid
                    && (state == ST_RUN || state == ST_STEP || state == ST_PAUSE)
                    && (dir_code != cur_dir)
                    && !is_reversal(cur_dir, dir_code);

  snake_tick_div #(
    .P0 (P0),
    .P1 (P1),
    .P2 (P2),
    .P3 (P3),
    .CW (CW)
  ) u_tick_div (
    .clk        (clk),
    .rst        (rst),
    .speed_mode (speed_mode),
    .run        (state == ST_RUN),
    .clear      (state == ST_IDLE || state == ST_STEP || state == ST_OVER),
    .tick       (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_dir    <= DIR_RIGHT;
      pend_dir   <= DIR_RIGHT;
      pend_valid <= 1'b0;
      pause_pend <= 1'b0;
      key_q      <= 1'b0;
      beep_cnt   <= '0;
      init_req   <= 1'b0;
      step_req   <= 1'b0;
      step_dir   <= DIR_RIGHT;
    end else begin
      key_q    <= key;
      init_req <= 1'b0;
      if (beep_cnt != '0) beep_cnt <= beep_cnt - CW'(1);

      case (state)
        ST_IDLE: begin
          if (key_rise) begin
            init_req   <= 1'b1;
            cur_dir    <= DIR_RIGHT;
            pend_valid <= 1'b0;
            pause_pend <= 1'b0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            cur_dir    <= next_dir;
            pend_valid <= 1'b0;
            step_req   <= 1'b1;
            step_dir   <= next_dir;
            state      <= ST_STEP;
            if (key_rise) pause_pend <= 1'b1;
          end else if (key_rise) begin
            state <= ST_PAUSE;
          end
        end
        ST_STEP: begin
          if (step_ack) begin
            step_req   <= 1'b0;
            pause_pend <= 1'b0;
            if (collision) begin
              beep_cnt <= BEEP_OVER_C;
              state    <= ST_OVER;
            end else begin
              if (eat) beep_cnt <= BEEP_EAT_C;
              state <= (pause_pend || key_rise) ? ST_PAUSE : ST_RUN;
            end
          end else if (key_rise) begin
            pause_pend <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (key_rise) state <= ST_RUN;
        end
        ST_OVER: begin
          if (key_rise) begin
            beep_cnt <= '0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Placed after the case so a fresh command survives a same-cycle commit.
      if (dir_accept) begin
        pend_dir   <= dir_code;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Bench for snake_step_scheduler: directed vector table plus randomized traffic,
// every cycle compared against a behavioural game model.
module tb_snake_step_scheduler;

  localparam int TP0 = 10, TP1 = 7, TP2 = 5, TP3 = 3;
  localparam int TBE = 4, TBO = 8;

  logic       clk = 1'b0;
  logic       rst, key, dir_valid, step_ack, collision, eat;
  logic [1:0] speed_mode, dir_code;
  logic       init_req, step_req, beep_en;
  logic [1:0] step_dir;
  logic [2:0] game_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snake_step_scheduler #(
    .P0 (TP0), .P1 (TP1), .P2 (TP2), .P3 (TP3),
    .BEEP_EAT (TBE), .BEEP_OVER (TBO), .CW (24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .speed_mode (speed_mode),
    .key        (key),
    .dir_valid  (dir_valid),
    .dir_code   (dir_code),
    .step_ack   (step_ack),
    .collision  (collision),
    .eat        (eat),
    .init_req   (init_req),
    .step_req   (step_req),
    .step_dir   (step_dir),
    .game_state (game_state),
    .beep_en    (beep_en)
  );

  // Behavioural model: state 0 idle, 1 running, 2 waiting for ack, 3 paused, 4 over.
  int m_state, m_dir, m_pend, m_sdir, m_beep, m_elapsed;
  bit m_pend_ok, m_latch, m_req, m_init, m_kprev;

  function automatic int period_of(input int s);
    case (s)
      0: return TP0;
      1: return TP1;
      2: return TP2;
      default: return TP3;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic run_cycle();
    int ns, nd, np, nsd, nb, ne;
    bit npo, nl, nr, ni, rise, accept;
    rise = key && !m_kprev;
    ns = m_state; nd = m_dir; np = m_pend; nsd = m_sdir; ne = m_elapsed;
    npo = m_pend_ok; nl = m_latch; nr = m_req; ni = 0;
    nb = (m_beep > 0) ? m_beep - 1 : 0;
    accept = (m_state >= 1 && m_state <= 3) && dir_valid
             && (int'(dir_code) != m_dir) && (int'(dir_code) != (m_dir ^ 2));
    case (m_state)
      0: begin
        ne = 0;
        if (rise) begin ni = 1; nd = 1; npo = 0; nl = 0; ns = 1; end
      end
      1: begin
        if (m_elapsed >= period_of(int'(speed_mode)) - 1) begin
          ne = 0;
          if (m_pend_ok) nd = m_pend;
          npo = 0; nr = 1; nsd = nd; ns = 2;
          if (rise) nl = 1;
        end else begin
          ne = m_elapsed + 1;
          if (rise) ns = 3;
        end
      end
      2: begin
        ne = 0;
        if (step_ack) begin
          nr = 0; nl = 0;
          if (collision) begin nb = TBO; ns = 4; end
          else begin
            if (eat) nb = TBE;
            ns = (m_latch || rise) ? 3 : 1;
          end
        end else if (rise) nl = 1;
      end
      3: if (rise) ns = 1;
      default: begin
        ne = 0;
        if (rise) begin ns = 0; nb = 0; end
      end
    endcase
    if (accept) begin np = int'(dir_code); npo = 1; end
    if (rst) begin
      ns = 0; nd = 1; np = 1; npo = 0; nl = 0; nr = 0; nsd = 1; ni = 0; nb = 0; ne = 0;
    end
    @(posedge clk);
    m_state = ns; m_dir = nd; m_pend = np; m_pend_ok = npo; m_latch = nl;
    m_req = nr; m_sdir = nsd; m_init = ni; m_beep = nb; m_elapsed = ne;
    m_kprev = rst ? 1'b0 : key;
    @(negedge clk);
    chk("game_state", int'(game_state), m_state);
    chk("step_req",   int'(step_req),   int'(m_req));
    chk("step_dir",   int'(step_dir),   m_sdir);
    chk("init_req",   int'(init_req),   int'(m_init));
    chk("beep_en",    int'(beep_en),    int'(m_beep != 0));
  endtask

  typedef struct {
    int         n;
    logic       rst, key, dv;
    logic [1:0] dc;
    logic       ack, col, eat;
    logic [1:0] spd;
    logic [2:0] st;
    logic       req;
    logic [1:0] sdir;
    logic       init, beep;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic r, input logic k, input logic dv,
                     input logic [1:0] dc, input logic a, input logic c, input logic e,
                     input logic [1:0] sp, input logic [2:0] st, input logic rq,
                     input logic [1:0] sd, input logic in, input logic bp);
    vec_t v;
    v.n = n; v.rst = r; v.key = k; v.dv = dv; v.dc = dc; v.ack = a; v.col = c;
    v.eat = e; v.spd = sp; v.st = st; v.req = rq; v.sdir = sd; v.init = in; v.beep = bp;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1; key = 0; dir_valid = 0; dir_code = 0; step_ack = 0;
    collision = 0; eat = 0; speed_mode = 0;
    m_kprev = 0;

    //  n  rs ky dv dc ak cl et sp | st rq sd in bp
    add( 2, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0);  // reset values
    add( 1, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 0);  // start, init pulse
    add( 1, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add( 8, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add( 1, 0, 0, 0, 0, 0, 0, 0, 0,  2, 1, 1, 0, 0);  // 10th run cycle ticks
    add( 1, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 1, 0, 0);
    add( 1, 0, 0, 1, 3, 0, 0, 0, 0,  1, 0, 1, 0, 0);  // reversal dropped
    add( 1, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add( 1, 0, 0, 1, 2, 0, 0, 0, 0,  1, 0, 1, 0, 0);  // checked vs right, kept
    add( 6, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add( 1, 0, 0, 0, 0, 0, 0, 0, 0,  2, 1, 2, 0, 0);
    add( 5, 0, 0, 0, 0, 0, 0, 0, 0,  2, 1, 2, 0, 0);  // delayed ack
    add( 1, 0, 0, 0, 0, 1, 0, 1, 0,  1, 0, 2, 0, 1);  // eat beep
    add( 3, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 1);
    add( 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0);
    add( 2, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0);
    add( 1, 0, 1, 0, 0, 0, 0, 0, 0,  3, 0, 2, 0, 0);  // pause at count 6
    add(50, 0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 2, 0, 0);
    add( 1, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0);  // resume
    add( 2, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0);
    add( 1, 0, 1, 0, 0, 0, 0, 0, 0,  2, 1, 2, 0, 0);
    add( 1, 0, 0, 0, 0, 0, 0, 0, 0,  2, 1, 2, 0, 0);
    add( 1, 0, 1, 0, 0, 0, 0, 0, 0,  2, 1, 2, 0, 0);  // pause latched in step
    add( 1, 0, 1, 0, 0, 1, 0, 0, 0,  3, 0, 2, 0, 0);
    add( 1, 0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 2, 0, 0);
    add( 1, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0);
    add( 1, 0, 0, 0, 0, 1, 1, 1, 0,  1, 0, 2, 0, 0);  // stray ack ignored
    add( 8, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0);
    add( 1, 0, 0, 0, 0, 0, 0, 0, 0,  2, 1, 2, 0, 0);
    add( 1, 0, 0, 0, 0, 1, 1, 0, 0,  4, 0, 2, 0, 1);  // collision
    add( 7, 0, 0, 0, 0, 0, 0, 0, 0,  4, 0, 2, 0, 1);
    add( 1, 0, 0, 0, 0, 0, 0, 0, 0,  4, 0, 2, 0, 0);
    add(20, 0, 0, 0, 0, 0, 0, 0, 0,  4, 0, 2, 0, 0);
    add( 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 0);
    add( 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 0);
    add( 1, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 2, 1, 0);  // restart
    add( 7, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0);
    add( 1, 0, 0, 0, 0, 0, 0, 0, 3,  2, 1, 1, 0, 0);  // shorter period fires now
    add( 2, 0, 0, 0, 0, 0, 0, 0, 3,  2, 1, 1, 0, 0);
    add( 1, 1, 0, 0, 0, 0, 0, 0, 3,  0, 0, 1, 0, 0);  // reset mid-handshake

    foreach (tbl[i]) begin
      rst = tbl[i].rst; key = tbl[i].key; dir_valid = tbl[i].dv; dir_code = tbl[i].dc;
      step_ack = tbl[i].ack; collision = tbl[i].col; eat = tbl[i].eat;
      speed_mode = tbl[i].spd;
      for (int c = 0; c < tbl[i].n; c++) run_cycle();
      chk($sformatf("row%0d_state", i), int'(game_state), int'(tbl[i].st));
      chk($sformatf("row%0d_step_req", i), int'(step_req), int'(tbl[i].req));
      chk($sformatf("row%0d_step_dir", i), int'(step_dir), int'(tbl[i].sdir));
      chk($sformatf("row%0d_init_req", i), int'(init_req), int'(tbl[i].init));
      chk($sformatf("row%0d_beep_en", i), int'(beep_en), int'(tbl[i].beep));
    end

    speed_mode = 2'($urandom_range(0, 3));
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0) key = ~key;
      dir_valid = ($urandom_range(0, 3) == 0);
      dir_code  = 2'($urandom_range(0, 3));
      step_ack  = ($urandom_range(0, 2) == 0);
      collision = ($urandom_range(0, 11) == 0);
      eat       = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) speed_mode = 2'($urandom_range(0, 3));
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snake_step_scheduler.md
Name: snake_step_scheduler

Overview:
- Game-sequencing controller for the snake datapath (body RAM, food logic, VGA renderer).
- Generates move ticks at a rate selected by speed_mode and arbitrates PS/2 direction commands, rejecting 180° reversals.
- Handles start, pause and restart from the key button, and issues one handshaked step request per tick to the datapath.
- Stops on collision and drives a beep enable for eat and game-over events.

Parameters:
- P0, 12500000, step period in clk cycles for speed_mode 0 (2 Hz at 25 MHz)
- P1, 6250000, step period for speed_mode 1
- P2, 3125000, step period for speed_mode 2
- P3, 1562500, step period for speed_mode 3
- BEEP_EAT, 2500000, beep_en length in cycles after an eat
- BEEP_OVER, 12500000, beep_en length in cycles after game over
- CW, 24, tick/beep counter width; must hold max(P*, BEEP_*)

Ports:
- clk  in  1  system clock, 25 MHz
- rst  in  1  synchronous reset, active-high
- speed_mode  in  2  step-rate select
- key  in  1  debounced start/pause button, level
- dir_valid  in  1  one-cycle strobe from PS/2 decoder
- dir_code  in  2  00 up, 01 right, 10 down, 11 left
- step_ack  in  1  datapath finished step
- collision  in  1  valid only when step_ack=1
- eat  in  1  valid only when step_ack=1
- init_req  out  1  one-cycle pulse: datapath reinitialises snake/food
- step_req  out  1  step request, held until ack
- step_dir  out  2  direction for the requested step
- game_state  out  3  IDLE=0, RUN=1, STEP=2, PAUSE=3, OVER=4
- beep_en  out  1  buzzer enable

Behaviour:
- Reset:
  - state=IDLE; cur_dir=01; pend_valid=0.
  - tick_cnt=0, beep_cnt=0.
  - All outputs 0 except step_dir=01.
- key_rise = key & ~key_q, where key_q is a registered copy of key (reset 0).
- IDLE:
  - On key_rise: init_req=1 for 1 cycle; cur_dir=01; pend_valid=0; tick_cnt=0; go to RUN.
- RUN:
  - tick_cnt increments each cycle.
  - period = P[speed_mode], sampled every cycle.
  - When tick_cnt >= period-1 (covers a speed change to a shorter period):
    - tick_cnt=0.
    - If pend_valid, cur_dir ← pend_dir and clear pend_valid.
    - Set step_req=1 and step_dir = the new cur_dir in the same register update; go to STEP.
  - On key_rise (with no tick in that cycle): go to PAUSE with tick_cnt frozen.
  - If key_rise and tick coincide, the tick wins and the pause is latched (pause_pend=1).
- STEP:
  - step_req and step_dir are held stable until step_ack.
  - tick_cnt is held at 0.
  - On step_ack: step_req=0 the next cycle.
    - collision=1 → OVER; beep_cnt=BEEP_OVER.
    - Else if eat=1 → beep_cnt=BEEP_EAT.
    - Then go to PAUSE if pause_pend, else RUN (clear pause_pend).
  - key_rise during STEP sets pause_pend.
- PAUSE:
  - Counter is frozen; direction commands are still buffered.
  - On key_rise: go to RUN and resume the count.
- OVER:
  - Direction commands are ignored.
  - On key_rise: go to IDLE. A second key_rise is then required to start; init_req is issued on IDLE→RUN.
- Direction arbitration (RUN, STEP, PAUSE only):
  - A dir_valid whose dir_code == cur_dir ^ 2'b10 (reversal) is dropped.
  - dir_code == cur_dir is dropped.
  - Otherwise pend_dir ← dir_code and pend_valid=1; the latest accepted command overwrites the buffer.
  - The check is always against the committed cur_dir, not pend_dir.
- Beep:
  - beep_en = (beep_cnt != 0); beep_cnt decrements to 0.
  - A new event reloads the counter; the larger remaining value does not matter.
  - beep_cnt is cleared on IDLE entry.
- Boundaries:
  - step_ack outside STEP is ignored.
  - collision/eat without ack are ignored.
  - rst in any state, including mid-handshake, returns to the reset values and drops step_req in the next cycle.
  - A speed change in PAUSE applies on resume.

Decomposition:
- Shared package snake_pkg holds:
  - state encoding constants (IDLE..OVER);
  - direction encodings DIR_UP/RIGHT/DOWN/LEFT;
  - the reversal-check function.
- One natural sub-module: snake_tick_div (period mux, counter, hold/clear controls, tick output).
- Direction buffer and FSM stay in the top.

Test Plan:
- Start: rst 2 cycles, key_rise → init_req high exactly 1 cycle, game_state=1. With P0=10 (overridden), the first step_req occurs 10 cycles after entering RUN, with step_dir=01.
- Reversal: in RUN with cur_dir=01, dir_valid 11 → dropped, next step_dir=01. Then dir_valid 00 followed by 10 → pend=10 (not a reversal of 01), next step_dir=10.
- Handshake: delay step_ack 5 cycles → step_req and step_dir stable for 5 cycles and no extra tick. Ack with eat=1 → beep_en high for BEEP_EAT cycles (overridden to 4).
- Collision: ack with collision=1 → game_state=4, beep_en high BEEP_OVER cycles, no further step_req. key_rise → IDLE; key_rise → init_req.
- Pause: key_rise in RUN at tick_cnt=6 → PAUSE, no step_req for 50 cycles. key_rise → step_req exactly 4 cycles later (P0=10). key_rise during STEP → PAUSE after ack.
- Speed/reset: switch speed_mode 0→3 (P3=3) when tick_cnt=7 → step_req next cycle. Assert rst during STEP → step_req=0 and state=IDLE the following cycle.
